// File: rtl/operand_sequencer.sv
// Operand sequencer for the 4-op ALU: conditions raw buttons, captures A/B/op from the
// board and supports chaining the ALU result back in as the next operand A.
module operand_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] switches,
    input  logic         btn_enter,
    input  logic [3:0]   btn_op,
    input  logic         btn_clear,
    input  logic [N-1:0] resultado_alu,
    output logic [N-1:0] numero_a,
    output logic [N-1:0] numero_b,
    output logic [3:0]   operacion,
    output logic [1:0]   estado,
    output logic         resultado_listo
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam int NB = 6;

    // Button bit map: [0] enter, [4:1] op, [5] clear
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] edge_det;
    assign raw_btn = {btn_clear, btn_op, btn_enter};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_cond
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end

            assign edge_det[gi] = sync2_reg & ~prev_reg;
        end
    endgenerate

    // Events are masked until the synchronisers hold post-reset samples, so a
    // button already held at reset release never looks like a fresh press.
    logic [2:0] arm_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_reg <= 3'b000;
        end else begin
            arm_reg <= {arm_reg[1:0], 1'b1};
        end
    end

    logic       enter_ev;
    logic       clear_ev;
    logic [3:0] op_ev;
    logic       op_valid;

    assign enter_ev = edge_det[0] & arm_reg[2];
    assign clear_ev = edge_det[5] & arm_reg[2];
    assign op_ev    = edge_det[4:1] & {4{arm_reg[2]}};
    assign op_valid = (op_ev != 4'd0) && ((op_ev & (op_ev - 4'd1)) == 4'd0);

    state_t       state_reg, state_next;
    logic [N-1:0] numero_a_reg, numero_a_next;
    logic [N-1:0] numero_b_reg, numero_b_next;
    logic [3:0]   operacion_reg, operacion_next;
    logic         listo_reg, listo_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= WAIT_A;
            numero_a_reg  <= '0;
            numero_b_reg  <= '0;
            operacion_reg <= 4'd0;
            listo_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            numero_a_reg  <= numero_a_next;
            numero_b_reg  <= numero_b_next;
            operacion_reg <= operacion_next;
            listo_reg     <= listo_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        numero_a_next  = numero_a_reg;
        numero_b_next  = numero_b_reg;
        operacion_next = operacion_reg;
        listo_next     = listo_reg;

        if (clear_ev) begin
            state_next     = WAIT_A;
            numero_a_next  = '0;
            numero_b_next  = '0;
            operacion_next = 4'd0;
            listo_next     = 1'b0;
        end else begin
            case (state_reg)
                WAIT_A: begin
                    if (enter_ev) begin
                        numero_a_next = switches;
                        state_next    = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (enter_ev) begin
                        numero_b_next = switches;
                        state_next    = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (op_valid) begin
                        operacion_next = op_ev;
                        listo_next     = 1'b1;
                        state_next     = SHOW;
                    end
                end
                SHOW: begin
                    // Enter wins over a simultaneous op press: the chain step is taken
                    if (enter_ev) begin
                        numero_a_next  = resultado_alu;
                        operacion_next = 4'd0;
                        listo_next     = 1'b0;
                        state_next     = WAIT_B;
                    end else if (op_valid) begin
                        operacion_next = op_ev;
                    end
                end
                default: begin
                    state_next = WAIT_A;
                end
            endcase
        end
    end

    assign numero_a        = numero_a_reg;
    assign numero_b        = numero_b_reg;
    assign operacion       = operacion_reg;
    assign estado          = state_reg;
    assign resultado_listo = listo_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a tiny combinational ALU closing the chain loop.
module tb_operand_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] switches;
    logic         btn_enter;
    logic [3:0]   btn_op;
    logic         btn_clear;
    logic [N-1:0] resultado_alu;
    logic [N-1:0] numero_a;
    logic [N-1:0] numero_b;
    logic [3:0]   operacion;
    logic [1:0]   estado;
    logic         resultado_listo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.N(N)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .switches        (switches),
        .btn_enter       (btn_enter),
        .btn_op          (btn_op),
        .btn_clear       (btn_clear),
        .resultado_alu   (resultado_alu),
        .numero_a        (numero_a),
        .numero_b        (numero_b),
        .operacion       (operacion),
        .estado          (estado),
        .resultado_listo (resultado_listo)
    );

    // Stand-in for the 4-op ALU
    always_comb begin
        resultado_alu = '0;
        case (operacion)
            4'b0001: resultado_alu = numero_a + numero_b;
            4'b0010: resultado_alu = numero_a - numero_b;
            4'b0100: resultado_alu = numero_a & numero_b;
            4'b1000: resultado_alu = numero_a | numero_b;
            default: resultado_alu = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Apply a button pattern for 'hold' cycles, release, then let the pipeline settle
    task automatic drive(input logic enter, input logic [3:0] op, input logic clr,
                         input logic [N-1:0] sw, input int hold);
        @(negedge clk);
        switches  = sw;
        btn_enter = enter;
        btn_op    = op;
        btn_clear = clr;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_op    = 4'd0;
        btn_clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [3:0] op, input logic [1:0] st, input logic rdy);
        check({tag, ".a"},     32'(numero_a),        32'(a));
        check({tag, ".b"},     32'(numero_b),        32'(b));
        check({tag, ".op"},    32'(operacion),       32'(op));
        check({tag, ".st"},    32'(estado),          32'(st));
        check({tag, ".listo"}, 32'(resultado_listo), 32'(rdy));
    endtask

    initial begin
        reset_n   = 1'b0;
        switches  = '0;
        btn_enter = 1'b1;   // held across reset release: must not register
        btn_op    = 4'd0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 8'd0, 8'd0, 4'd0, 2'd0, 1'b0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("held_at_release.st", 32'(estado), 32'd0);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);

        // Basic add with latency check on the op press
        drive(1'b1, 4'd0, 1'b0, 8'd12, 2);
        check_all("capA", 8'd12, 8'd0, 4'd0, 2'd1, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 8'd30, 2);
        check_all("capB", 8'd12, 8'd30, 4'd0, 2'd2, 1'b0);
        @(negedge clk);
        btn_op = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("latency_E1.st", 32'(estado), 32'd2);
        @(negedge clk);
        check("latency_E2.st", 32'(estado), 32'd3);
        btn_op = 4'd0;
        repeat (4) @(negedge clk);
        check_all("add", 8'd12, 8'd30, 4'b0001, 2'd3, 1'b1);
        check("add.alu", 32'(resultado_alu), 32'd42);

        // Chain result into A, then subtract with wrap
        drive(1'b1, 4'd0, 1'b0, 8'd99, 2);
        check_all("chain", 8'd42, 8'd30, 4'd0, 2'd1, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 8'd50, 2);
        drive(1'b0, 4'b0010, 1'b0, 8'd0, 2);
        check_all("sub", 8'd42, 8'd50, 4'b0010, 2'd3, 1'b1);
        check("sub.alu", 32'(resultado_alu), 32'hF8);

        // New op while showing: same operands, new function
        drive(1'b0, 4'b0100, 1'b0, 8'd0, 2);
        check_all("show_and", 8'd42, 8'd50, 4'b0100, 2'd3, 1'b1);
        check("show_and.alu", 32'(resultado_alu), 32'd34);

        // Clear from SHOW
        drive(1'b0, 4'd0, 1'b1, 8'd0, 2);
        check_all("clear_show", 8'd0, 8'd0, 4'd0, 2'd0, 1'b0);

        // Op ignored in WAIT_A, long enter gives a single capture
        drive(1'b0, 4'b0001, 1'b0, 8'd0, 2);
        check_all("op_in_waita", 8'd0, 8'd0, 4'd0, 2'd0, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 8'd7, 20);
        check_all("held_enter", 8'd7, 8'd0, 4'd0, 2'd1, 1'b0);

        // Clear beats a simultaneous enter in WAIT_B
        drive(1'b1, 4'd0, 1'b1, 8'd9, 2);
        check_all("clear_enter", 8'd0, 8'd0, 4'd0, 2'd0, 1'b0);

        // Illegal two-button op, then a legal OR, then sub underflow
        drive(1'b1, 4'd0, 1'b0, 8'd3, 2);
        drive(1'b1, 4'd0, 1'b0, 8'd5, 2);
        drive(1'b0, 4'b0101, 1'b0, 8'd0, 2);
        check_all("illegal_op", 8'd3, 8'd5, 4'd0, 2'd2, 1'b0);
        drive(1'b0, 4'b1000, 1'b0, 8'd0, 2);
        check_all("or_op", 8'd3, 8'd5, 4'b1000, 2'd3, 1'b1);
        check("or_op.alu", 32'(resultado_alu), 32'd7);
        drive(1'b0, 4'b0010, 1'b0, 8'd0, 2);
        check("sub_wrap.alu", 32'(resultado_alu), 32'hFE);

        // Asynchronous reset mid-SHOW takes effect before the next clock edge
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_all("async_rst", 8'd0, 8'd0, 4'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst.st", 32'(estado), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
